rf_mp: RTL

- Parametrised multi-port register file; next generation of the core's integer register file.
- Configurable data width, depth and read-port count.
- Two write ports with fixed priority and optional write-to-read bypass.
- Sequential bulk-clear engine with busy flag. Sits between decode (read addresses) and writeback (two retire lanes).

---
 rtl/rf_mp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
// Module   : rf_mp
// Purpose  : Parametrised multi-port integer register file. NRD
//            combinational read ports, two write lanes (lane 1 has priority),
//            optional same-cycle write-to-read bypass, optional hard-wired
//            zero register, and a sequential bulk-clear engine.
// Ports    :
//   clk_i    in   1          clock, rising edge
//   reset    in   1          synchronous active-low reset
//   ra_i     in   NRD*AW     read addresses, port k at [k*AW +: AW]
//   rd_o     out  NRD*XLEN   read data, port k at [k*XLEN +: XLEN]
//   we0_i    in   1          lane 0 write enable
//   wa0_i    in   AW         lane 0 write address
//   wd0_i    in   XLEN       lane 0 write data
//   we1_i    in   1          lane 1 write enable (priority lane)
//   wa1_i    in   AW         lane 1 write address
//   wd1_i    in   XLEN       lane 1 write data
//   clear_i  in   1          pulse that starts a sequential clear
//   busy_o   out  1          high while the clear engine runs (registered)
// Revision : 1.0 - initial release
// ============================================================================
module rf_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra_i,
  output logic [NRD*XLEN-1:0] rd_o,
  input  logic                we0_i,
  input  logic [AW-1:0]       wa0_i,
  input  logic [XLEN-1:0]     wd0_i,
  input  logic                we1_i,
  input  logic [AW-1:0]       wa1_i,
  input  logic [XLEN-1:0]     wd1_i,
  input  logic                clear_i,
  output logic                busy_o
);

  localparam logic [AW-1:0] C_LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] C_IDX_ONE  = AW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            busy_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic idle;
  logic wv0, wv1;

  assign idle = (state_q == S_IDLE);

  // A write is live only while idle and, with a hard-wired zero register,
  // never to address 0. The same qualification gates storage and bypass.
  assign wv0 = we0_i && idle && !((ZERO_REG != 0) && (wa0_i == '0));
  assign wv1 = we1_i && idle && !((ZERO_REG != 0) && (wa1_i == '0));

  // --------------------------------------------------------------------------
  // Clear engine: IDLE -> CLEAR on clear_i, sweep index 0..DEPTH-1, back.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clear_i) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + C_IDX_ONE;
        if (idx_q == C_LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == S_CLEAR);
    end
  end

  assign busy_o = busy_q;

  // --------------------------------------------------------------------------
  // Storage. Lane 1 is written after lane 0 so it wins on an address clash.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == S_CLEAR) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wv0) mem_q[wa0_i] <= wd0_i;
      if (wv1) mem_q[wa1_i] <= wd1_i;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational read ports with optional bypass.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = ra_i[k*AW +: AW];

    always_comb begin
      rd = mem_q[ra];
      if (BYPASS != 0) begin
        if (wv0 && (wa0_i == ra)) rd = wd0_i;
        if (wv1 && (wa1_i == ra)) rd = wd1_i;
      end
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    end

    assign rd_o[k*XLEN +: XLEN] = rd;
  end

endmodule
`default_nettype wire
